alu_mdu_seq: RTL and testbench
==============================

// Module: alu_mdu_seq
// PURPOSE
//  Parametrised, registered ALU with an iterative RV32M-style multiply/divide unit.
//  It sits in the execute stage and replaces the combinational 3-bit ALU.
//  It adds SLT/SLTU and MUL/MULHU/DIV/DIVU/REM/REMU.
//  Operands are accepted and results returned over valid/ready handshakes.
//  Single-cycle ops and multi-cycle mul/div share one result register.
// PARAMETERS
//  WIDTH   32  operand/result width; power of 2, >=8; shamt = low $clog2(WIDTH) bits of SrcB
//  MDU_EN  1   1: mul/div implemented; 0: ops 1010-1111 return 0 with single-cycle latency
// PORTS
//  clk        in   1      single clock, all state updates on rising edge
//  reset      in   1      synchronous, active-high reset
//  in_valid   in   1      operation request
//  in_ready   out  1      block can accept; comb = !reset && state==IDLE && (!out_valid || out_ready)
//  SrcA       in   WIDTH  operand A (dividend / multiplicand)
//  SrcB       in   WIDTH  operand B (divisor / multiplier / shift amount)
//  ALUControl in   4      opcode, see BEHAVIOUR
//  out_valid  out  1      ALUResult/Zero valid; held until out_ready
//  out_ready  in   1      consumer takes result
//  ALUResult  out  WIDTH  registered result
//  Zero       out  1      registered, ALUResult == 0
//  busy       out  1      high while state==CALC
// BEHAVIOUR
//  Clock and reset:
//  - Single clock domain (clk).
//  - Reset is synchronous and active-high: sampled on the rising clk edge.
//  - Reset values: out_valid=0, ALUResult=0, Zero=0, busy=0, state=IDLE, count=0.
//  - in_ready is 0 while reset is high.
//  - Reset mid-CALC aborts the operation; no out_valid is produced.
//  Opcodes:
//  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 SLL, 0101 SRL, 0110 SRA, 0111 XOR.
//  - 1000 SLT (signed, result 0/1), 1001 SLTU (unsigned, result 0/1).
//  - 1010 MUL (low WIDTH bits), 1011 MULHU (high WIDTH bits, unsigned).
//  - 1100 DIVU, 1101 REMU, 1110 DIV (signed), 1111 REM (signed).
//  - All arithmetic wraps modulo 2^WIDTH.
//  Accept and single-cycle latency:
//  - An op is accepted at edge k when in_valid && in_ready.
//  - Ops 0000-1001 (and all ops when MDU_EN=0) load ALUResult and Zero at edge k.
//  - For these ops out_valid=1 from edge k through the handshake.
//  States:
//  - IDLE: waits for a request.
//  - CALC: iterative compute; busy=1, in_ready=0.
//  - DONE is implicit: out_valid=1 with state returned to IDLE.
//  Iterative mul/div:
//  - Accepting an iterative op latches operands and opcode, sets count=0, enters CALC.
//  - One bit per cycle: shift-add for mul, restoring divide on magnitudes for div/rem.
//  - After WIDTH iterations (edges k+1..k+WIDTH) the result loads at edge k+WIDTH.
//  - out_valid=1 from edge k+WIDTH; state returns to IDLE.
//  - Latency = WIDTH cycles; e.g. WIDTH=32 gives 32 cycles.
//  - DIV/REM signs: quotient negative iff operand signs differ; remainder takes dividend sign.
//  - Corrections are applied at completion.
//  Short-cut cases (single-cycle, no CALC):
//  - Divide by zero: DIV/DIVU = all ones; REM/REMU = SrcA.
//  - Signed overflow SrcA = 100..0, SrcB = all ones: DIV = SrcA; REM = 0.
//  Output handshake:
//  - Result is released when out_valid && out_ready at an edge.
//  - On release, out_valid clears unless a new single-cycle op is accepted at the same edge.
//  - Back-to-back single-cycle ops give full throughput when out_ready=1.
//  - While out_valid && !out_ready: ALUResult and Zero hold stable and in_ready=0.
//  Input ignored cases:
//  - in_valid while in_ready=0 is ignored; no buffering.
//  - Inputs are not sampled after acceptance; SrcA/SrcB may change during CALC.
// TESTING
//  Reset, then ADD 0x7FFFFFFF + 1, out_ready=1 -> next cycle ALUResult=0x80000000, Zero=0, out_valid=1.
//  SUB 5-5, then SLT 0xFFFFFFFF,1 back-to-back -> results 0/Zero=1, then 1/Zero=0 on consecutive cycles.
//  SRA 0x80000000 by SrcB=0x24 (shamt 4) -> 0xF8000000.
//  MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001 after 32 cycles; MULHU of same -> 0xFFFFFFFE; busy high 32 cycles.
//  DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF.
//  DIVU x/0 -> 0xFFFFFFFF and DIV 0x80000000/-1 -> 0x80000000, each in 1 cycle, busy never high.
//  Hold out_ready=0 for 5 cycles after MUL done -> result stable, in_ready=0.
//  Assert reset at cycle 10 of a DIV -> out_valid stays 0, in_ready=1 on the cycle after reset drops.

Source files
------------

// File: rtl/alu_mdu_seq.sv
// Registered execute-stage ALU with an iterative shift-add multiplier and restoring divider.
// Single-cycle ops and multi-cycle mul/div share one result register behind valid/ready handshakes.
module alu_mdu_seq #(
  parameter int WIDTH  = 32,
  parameter bit MDU_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             busy,
  output logic             dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // in_valid/SrcA/SrcB/ALUControl are sampled only at that edge; out_valid holds, with
  // ALUResult/Zero stable, until out_ready is seen high at an edge.

  localparam int SW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES    = '1;

  typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    count_q, count_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  logic [SW-1:0]    shamt;
  logic             is_mul_op, is_div_op, div_zero, div_ovf, iter_op, accept;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b, fast_res;
  logic [WIDTH:0]   mul_sum, div_rs, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo, final_res;

  assign shamt     = SrcB[SW-1:0];
  assign is_mul_op = (ALUControl[3:1] == 3'b101);
  assign is_div_op = (ALUControl[3:2] == 2'b11);
  assign div_zero  = (SrcB == '0);
  assign div_ovf   = ALUControl[1] && (SrcA == MIN_VAL) && (SrcB == ONES);
  assign iter_op   = MDU_EN && (is_mul_op || (is_div_op && !div_zero && !div_ovf));
  assign accept    = in_valid && in_ready;

  // ALUControl[1] marks the signed divide ops; the divider only ever sees magnitudes.
  assign a_neg = ALUControl[1] && SrcA[WIDTH-1];
  assign b_neg = ALUControl[1] && SrcB[WIDTH-1];
  assign mag_a = a_neg ? ('0 - SrcA) : SrcA;
  assign mag_b = b_neg ? ('0 - SrcB) : SrcB;

  always_comb begin
    fast_res = '0;
    case (ALUControl)
      4'b0000: fast_res = SrcA + SrcB;
      4'b0001: fast_res = SrcA - SrcB;
      4'b0010: fast_res = SrcA & SrcB;
      4'b0011: fast_res = SrcA | SrcB;
      4'b0100: fast_res = SrcA << shamt;
      4'b0101: fast_res = SrcA >> shamt;
      4'b0110: fast_res = $unsigned($signed(SrcA) >>> shamt);
      4'b0111: fast_res = SrcA ^ SrcB;
      4'b1000: fast_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      4'b1001: fast_res = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
      default: begin
        // Divide shortcuts; iterative ops never take this value.
        if (MDU_EN && is_div_op) begin
          if (div_zero) fast_res = ALUControl[0] ? SrcA : ONES;
          else          fast_res = ALUControl[0] ? '0 : SrcA;
        end
      end
    endcase
  end

  // One iteration: hi/lo hold {product high, multiplier/product low} or {remainder, quotient}.
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_rs   = {hi_q, lo_q[WIDTH-1]};
  assign div_diff = div_rs - {1'b0, opnd_q};
  assign div_ge   = !div_diff[WIDTH];
  assign step_hi  = op_q[2] ? (div_ge ? div_diff[WIDTH-1:0] : div_rs[WIDTH-1:0])
                            : mul_sum[WIDTH:1];
  assign step_lo  = op_q[2] ? {lo_q[WIDTH-2:0], div_ge}
                            : {mul_sum[0], lo_q[WIDTH-1:1]};

  always_comb begin
    final_res = step_lo;
    case (op_q)
      4'b1011: final_res = step_hi;
      4'b1101: final_res = step_hi;
      4'b1110: final_res = q_neg_q ? ('0 - step_lo) : step_lo;
      4'b1111: final_res = r_neg_q ? ('0 - step_hi) : step_hi;
      default: final_res = step_lo;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      op_q        <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      op_q        <= op_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      opnd_q      <= opnd_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    op_d        = op_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    opnd_d      = opnd_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    zero_d      = zero_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (iter_op) begin
            state_d = CALC;
            count_d = '0;
            op_d    = ALUControl;
            hi_d    = '0;
            lo_d    = is_mul_op ? SrcB : mag_a;
            opnd_d  = is_mul_op ? SrcA : mag_b;
            q_neg_d = a_neg ^ b_neg;
            r_neg_d = a_neg;
          end else begin
            result_d    = fast_res;
            zero_d      = (fast_res == '0);
            out_valid_d = 1'b1;
          end
        end
      end
      CALC: begin
        hi_d    = step_hi;
        lo_d    = step_lo;
        count_d = count_q + 1'b1;
        if (count_q == SW'(WIDTH-1)) begin
          state_d     = IDLE;
          result_d    = final_res;
          zero_d      = (final_res == '0);
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = !reset && (state_q == IDLE) && (!out_valid_q || out_ready);
    busy        = (state_q == CALC);
    dbg_state_o = state_q;
    out_valid   = out_valid_q;
    ALUResult   = result_q;
    Zero        = zero_q;
  end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed bench for alu_mdu_seq (WIDTH=32): single-cycle ops, mul/div latency,
// divide shortcuts, output back-pressure and reset abort.
module tb_alu_mdu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [3:0]  ALUControl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        busy;
  logic        dbg_state_o;

  int checks   = 0;
  int failures = 0;

  alu_mdu_seq #(.WIDTH(32), .MDU_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
    .out_valid(out_valid), .out_ready(out_ready), .ALUResult(ALUResult),
    .Zero(Zero), .busy(busy), .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid   = 1'b1;
    ALUControl = op;
    SrcA       = a;
    SrcB       = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    while (!out_valid && cyc < 100) begin
      if (busy) bcnt++;
      step();
      cyc++;
    end
  endtask

  task automatic run_iter(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    int cyc, bcnt;
    issue(op, a, b);
    SrcA = 32'hDEAD_BEEF;
    SrcB = 32'h1234_5678;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(cyc, bcnt);
    check({tag, "_latency"}, 32'(cyc), 32'd32);
    check({tag, "_result"}, ALUResult, exp);
  endtask

  initial begin
    int cyc, bcnt, ov_seen;
    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    SrcA       = '0;
    SrcB       = '0;
    ALUControl = '0;
    repeat (3) step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", ALUResult, 32'd0);
    check("rst_zero", 32'(Zero), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    issue(4'b0000, 32'h7FFF_FFFF, 32'h1);
    check("add_result", ALUResult, 32'h8000_0000);
    check("add_zero", 32'(Zero), 32'd0);
    check("add_valid", 32'(out_valid), 32'd1);

    // Back-to-back single-cycle ops while the previous result is being taken.
    in_valid = 1'b1; ALUControl = 4'b0001; SrcA = 32'd5; SrcB = 32'd5;
    step();
    check("sub_result", ALUResult, 32'd0);
    check("sub_zero", 32'(Zero), 32'd1);
    check("b2b_in_ready", 32'(in_ready), 32'd1);
    ALUControl = 4'b1000; SrcA = 32'hFFFF_FFFF; SrcB = 32'd1;
    step();
    in_valid = 1'b0;
    check("slt_result", ALUResult, 32'd1);
    check("slt_zero", 32'(Zero), 32'd0);

    issue(4'b1001, 32'hFFFF_FFFF, 32'd1);
    check("sltu_result", ALUResult, 32'd0);
    issue(4'b0110, 32'h8000_0000, 32'h24);
    check("sra_result", ALUResult, 32'hF800_0000);
    issue(4'b0100, 32'h0000_0003, 32'h21);
    check("sll_result", ALUResult, 32'h0000_0006);
    issue(4'b0101, 32'h8000_0000, 32'h1F);
    check("srl_result", ALUResult, 32'h0000_0001);
    issue(4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00);
    check("xor_result", ALUResult, 32'h0FF0_0FF0);

    // MUL with busy-cycle count and the in-flight state checks.
    issue(4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    SrcA = '0;
    SrcB = '0;
    check("mul_in_ready_calc", 32'(in_ready), 32'd0);
    check("mul_state_calc", 32'(dbg_state_o), 32'd1);
    check("mul_valid_calc", 32'(out_valid), 32'd0);
    wait_done(cyc, bcnt);
    check("mul_latency", 32'(cyc), 32'd32);
    check("mul_busy_cycles", 32'(bcnt), 32'd32);
    check("mul_result", ALUResult, 32'h0000_0001);
    check("mul_busy_done", 32'(busy), 32'd0);

    // MULHU then back-pressure: result must hold and a new request be ignored.
    issue(4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    out_ready = 1'b0;
    wait_done(cyc, bcnt);
    check("mulhu_latency", 32'(cyc), 32'd32);
    in_valid = 1'b1; ALUControl = 4'b0000; SrcA = 32'd1; SrcB = 32'd1;
    for (int i = 0; i < 5; i++) begin
      check("hold_result", ALUResult, 32'hFFFF_FFFE);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_valid", 32'(out_valid), 32'd1);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_result", ALUResult, 32'hFFFF_FFFE);

    run_iter("div_neg", 4'b1110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_iter("rem_neg", 4'b1111, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_iter("div_negb", 4'b1110, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    run_iter("rem_negb", 4'b1111, 32'd7, 32'hFFFF_FFFE, 32'd1);
    run_iter("divu", 4'b1100, 32'd100, 32'd7, 32'd14);
    run_iter("remu", 4'b1101, 32'd100, 32'd7, 32'd2);
    run_iter("divu_big", 4'b1100, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF);

    // Shortcut cases complete in one cycle without entering CALC.
    issue(4'b1100, 32'h1234_5678, 32'd0);
    check("divu0_result", ALUResult, 32'hFFFF_FFFF);
    check("divu0_valid", 32'(out_valid), 32'd1);
    check("divu0_busy", 32'(busy), 32'd0);
    issue(4'b1101, 32'h1234_5678, 32'd0);
    check("remu0_result", ALUResult, 32'h1234_5678);
    issue(4'b1110, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_result", ALUResult, 32'h8000_0000);
    check("div_ovf_busy", 32'(busy), 32'd0);
    issue(4'b1111, 32'h8000_0000, 32'hFFFF_FFFF);
    check("rem_ovf_result", ALUResult, 32'd0);
    check("rem_ovf_zero", 32'(Zero), 32'd1);

    // Reset during an iterative divide aborts it.
    issue(4'b1110, 32'h0000_1000, 32'd3);
    repeat (9) step();
    check("abort_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    ov_seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) ov_seen++;
    end
    check("abort_no_result", 32'(ov_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
